// File: rtl/data_unpack.sv
// data_unpack: parses fixed-layout TDC frames (header / 40-bit word payload / seq trailer).
// Define DATA_UNPACK_SEQ_CHECK_EN to count trailer sequence discontinuities.
module data_unpack #(
    parameter logic [47:0] EXP_SRCADDR   = 48'hFFFFFFC70501,
    parameter logic [15:0] EXP_LOADBYTE  = 16'h0064,
    parameter logic [15:0] PRELOAD_BYTE  = 16'd14,
    parameter logic [15:0] POSTLOAD_BYTE = 16'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [7:0]  rx_axis_tdata,
    input  logic        rx_axis_tvalid,
    input  logic        rx_axis_tlast,
    output logic        rx_axis_tready,
    output logic [39:0] tdc_word,
    output logic        tdc_valid,
    input  logic        tdc_ready,
    output logic [15:0] frame_count,
    output logic [15:0] drop_count,
    output logic [15:0] runt_count,
    output logic [15:0] seq_err_count,
    output logic [15:0] last_seq
);
    localparam logic [15:0] SRC_FIRST = 16'd7;
    localparam logic [15:0] SRC_LAST  = 16'd12;
    localparam logic [15:0] PAY_END   = PRELOAD_BYTE + EXP_LOADBYTE;
    localparam logic [15:0] FRM_END   = PAY_END + POSTLOAD_BYTE;

    typedef enum logic [2:0] {S_IDLE, S_HEADER, S_PAYLOAD, S_TRAILER, S_DROP} state_t;

    state_t      r_state, w_next;
    logic [15:0] r_cnt;
    logic [2:0]  r_phase;
    logic [31:0] r_shift;
    logic [7:0]  r_seq_hi;
    logic [39:0] r_tdc_word;
    logic        r_tdc_valid;
    logic [15:0] r_frame_cnt, r_drop_cnt, r_runt_cnt, r_last_seq;

    logic [15:0] w_idx, w_seq;
    logic [39:0] w_word;
    logic [47:0] w_src_sh;
    logic [7:0]  w_exp_byte;
    logic        w_chk, w_mismatch, w_acc, w_tready;
    logic        w_good, w_drop, w_runt, w_word_done, w_emit;

    // w_idx is the 1-based frame position of the byte currently on the bus
    assign w_idx    = r_cnt + 16'd1;
    assign w_tready = !((r_state == S_PAYLOAD) && (r_phase == 3'd4) && r_tdc_valid && !tdc_ready);
    assign w_acc    = rx_axis_tvalid & w_tready;
    assign w_word   = {r_shift, rx_axis_tdata};
    assign w_seq    = {r_seq_hi, rx_axis_tdata};
    assign w_emit   = w_word_done && (w_word != {40{1'b1}});

    always_comb begin
        w_src_sh   = EXP_SRCADDR >> {SRC_LAST - w_idx, 3'b000};
        w_exp_byte = 8'h00;
        w_chk      = 1'b0;
        if (w_idx >= SRC_FIRST && w_idx <= SRC_LAST) begin
            w_chk      = 1'b1;
            w_exp_byte = w_src_sh[7:0];
        end else if (w_idx == PRELOAD_BYTE - 16'd1) begin
            w_chk      = 1'b1;
            w_exp_byte = EXP_LOADBYTE[15:8];
        end else if (w_idx == PRELOAD_BYTE) begin
            w_chk      = 1'b1;
            w_exp_byte = EXP_LOADBYTE[7:0];
        end
        w_mismatch = w_chk && (rx_axis_tdata != w_exp_byte);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_acc) begin
            case (r_state)
                S_IDLE:    w_next = rx_axis_tlast ? S_IDLE : (enable ? S_HEADER : S_DROP);
                S_HEADER: begin
                    if (w_mismatch)                 w_next = rx_axis_tlast ? S_IDLE : S_DROP;
                    else if (rx_axis_tlast)         w_next = S_IDLE;
                    else if (w_idx == PRELOAD_BYTE) w_next = S_PAYLOAD;
                end
                S_PAYLOAD: begin
                    if (rx_axis_tlast)         w_next = S_IDLE;
                    else if (w_idx == PAY_END) w_next = S_TRAILER;
                end
                S_TRAILER: begin
                    if (w_idx == FRM_END)   w_next = rx_axis_tlast ? S_IDLE : S_DROP;
                    else if (rx_axis_tlast) w_next = S_IDLE;
                end
                S_DROP:    if (rx_axis_tlast) w_next = S_IDLE;
                default:   w_next = S_IDLE;
            endcase
        end
    end

    // Per-frame events: at most one of good/drop/runt fires for any frame
    always_comb begin
        w_good      = 1'b0;
        w_drop      = 1'b0;
        w_runt      = 1'b0;
        w_word_done = 1'b0;
        if (w_acc) begin
            case (r_state)
                S_IDLE: begin
                    w_drop = !enable;
                    w_runt = enable && rx_axis_tlast;
                end
                S_HEADER: begin
                    w_drop = w_mismatch;
                    w_runt = !w_mismatch && rx_axis_tlast;
                end
                S_PAYLOAD: begin
                    w_runt      = rx_axis_tlast;
                    w_word_done = (r_phase == 3'd4);
                end
                S_TRAILER: begin
                    w_good = (w_idx == FRM_END) && rx_axis_tlast;
                    w_drop = (w_idx == FRM_END) && !rx_axis_tlast;
                    w_runt = (w_idx != FRM_END) && rx_axis_tlast;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_phase     <= '0;
            r_shift     <= '0;
            r_seq_hi    <= '0;
            r_tdc_word  <= '0;
            r_tdc_valid <= 1'b0;
        end else begin
            if (w_acc) begin
                r_cnt <= (r_state == S_IDLE) ? 16'd1 : r_cnt + 16'd1;
                if (r_state == S_PAYLOAD) begin
                    r_shift <= w_word[31:0];
                    r_phase <= (r_phase == 3'd4) ? 3'd0 : r_phase + 3'd1;
                end else begin
                    r_phase <= 3'd0;
                end
                if (r_state == S_TRAILER) r_seq_hi <= rx_axis_tdata;
            end
            if (w_emit) begin
                r_tdc_word  <= w_word;
                r_tdc_valid <= 1'b1;
            end else if (tdc_ready) begin
                r_tdc_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
            r_drop_cnt  <= '0;
            r_runt_cnt  <= '0;
            r_last_seq  <= '0;
        end else begin
            if (w_good) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
                r_last_seq  <= w_seq;
            end
            if (w_drop) r_drop_cnt <= r_drop_cnt + 16'd1;
            if (w_runt) r_runt_cnt <= r_runt_cnt + 16'd1;
        end
    end

`ifdef DATA_UNPACK_SEQ_CHECK_EN
    logic        r_seen_good;
    logic [15:0] r_seq_err;

    // The first good frame after reset only seeds the expected sequence
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seen_good <= 1'b0;
            r_seq_err   <= '0;
        end else if (w_good) begin
            r_seen_good <= 1'b1;
            if (r_seen_good && (w_seq != r_last_seq + 16'd1)) r_seq_err <= r_seq_err + 16'd1;
        end
    end
    assign seq_err_count = r_seq_err;
`else
    assign seq_err_count = 16'd0;
`endif

    assign rx_axis_tready = w_tready;
    assign tdc_word       = r_tdc_word;
    assign tdc_valid      = r_tdc_valid;
    assign frame_count    = r_frame_cnt;
    assign drop_count     = r_drop_cnt;
    assign runt_count     = r_runt_cnt;
    assign last_seq       = r_last_seq;
endmodule

// File: tb/tb_data_unpack.sv
// Randomized bench for data_unpack against a byte-level frame model.
module tb_data_unpack;
    logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b1;
    logic [7:0]  rx_axis_tdata = 8'h00;
    logic        rx_axis_tvalid = 1'b0, rx_axis_tlast = 1'b0;
    logic        rx_axis_tready;
    logic [39:0] tdc_word;
    logic        tdc_valid;
    logic        tdc_ready = 1'b1;
    logic [15:0] frame_count, drop_count, runt_count, seq_err_count, last_seq;

    data_unpack dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .rx_axis_tdata(rx_axis_tdata), .rx_axis_tvalid(rx_axis_tvalid),
        .rx_axis_tlast(rx_axis_tlast), .rx_axis_tready(rx_axis_tready),
        .tdc_word(tdc_word), .tdc_valid(tdc_valid), .tdc_ready(tdc_ready),
        .frame_count(frame_count), .drop_count(drop_count), .runt_count(runt_count),
        .seq_err_count(seq_err_count), .last_seq(last_seq)
    );

    always #4 clk = ~clk;

    int          n_cmp = 0, n_err = 0, byte_no = 0;
    logic [7:0]  fb[$];
    logic [7:0]  full[$];
    logic [39:0] wd[20];
    logic [39:0] exp_q[$], got_q[$];
    logic [15:0] m_frame = 0, m_drop = 0, m_runt = 0, m_seqerr = 0, m_last = 0;
    bit          m_seen = 0, stall = 0, rdy_full = 1, saw_lo = 0, held = 0;
    logic [39:0] held_w;
    logic [47:0] src_v = 48'hFFFFFFC70501;
    logic [15:0] seqs[5];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial forever begin
        @(negedge clk);
        tdc_ready = stall ? 1'b0 : (rdy_full ? 1'b1 : ($urandom_range(0, 3) != 0));
    end

    // Sample just before the rising edge: handshakes and hold-stability
    always @(negedge clk) begin
        #3;
        if (rst_n) begin
            if (held) begin
                chk("hold_vld", 64'(tdc_valid), 64'd1);
                chk("hold_word", 64'(tdc_word), 64'(held_w));
            end
            if (tdc_valid && tdc_ready) got_q.push_back(tdc_word);
            if (rx_axis_tvalid && !rx_axis_tready) saw_lo = 1;
            held   = tdc_valid && !tdc_ready;
            held_w = tdc_word;
        end else begin
            held = 0;
        end
    end

    task automatic model_frame(input bit en);
        int n;
        logic [39:0] w;
        logic [15:0] s;
        n = fb.size();
        w = '0;
        if (!en) begin m_drop += 16'd1; return; end
        for (int i = 1; i <= n; i++) begin
            if (i >= 7 && i <= 12 && fb[i-1] != src_v[8*(12-i) +: 8]) begin m_drop += 16'd1; return; end
            if ((i == 13 && fb[i-1] != 8'h00) || (i == 14 && fb[i-1] != 8'h64)) begin
                m_drop += 16'd1; return;
            end
            if (i >= 15 && i <= 114) begin
                w = {w[31:0], fb[i-1]};
                if ((i - 14) % 5 == 0 && w != 40'hFFFFFFFFFF) exp_q.push_back(w);
            end
            if (i == 118) begin
                if (n == 118) begin
                    s = {fb[116], fb[117]};
`ifdef DATA_UNPACK_SEQ_CHECK_EN
                    if (m_seen && s != 16'(m_last + 16'd1)) m_seqerr += 16'd1;
`endif
                    m_last  = s;
                    m_seen  = 1;
                    m_frame += 16'd1;
                end else begin
                    m_drop += 16'd1;
                end
                return;
            end
            if (i == n) begin m_runt += 16'd1; return; end
        end
    endtask

    task automatic build(input logic [15:0] seq);
        fb.delete();
        for (int i = 0; i < 6; i++) fb.push_back(8'($urandom));
        for (int i = 0; i < 6; i++) fb.push_back(src_v[47-8*i -: 8]);
        fb.push_back(8'h00);
        fb.push_back(8'h64);
        for (int w = 0; w < 20; w++)
            for (int b = 4; b >= 0; b--) fb.push_back(wd[w][8*b +: 8]);
        fb.push_back(8'h00);
        fb.push_back(8'h00);
        fb.push_back(seq[15:8]);
        fb.push_back(seq[7:0]);
    endtask

    task automatic rand_words();
        for (int w = 0; w < 20; w++)
            wd[w] = ($urandom_range(0, 3) == 0) ? 40'hFFFFFFFFFF : {8'($urandom), 32'($urandom)};
    endtask

    task automatic push_byte(input logic [7:0] d, input bit l);
        bit acc;
        int t;
        @(negedge clk);
        if ($urandom_range(0, 3) == 0) begin rx_axis_tvalid = 0; @(negedge clk); end
        rx_axis_tdata  = d;
        rx_axis_tvalid = 1;
        rx_axis_tlast  = l;
        acc = 0;
        t   = 0;
        while (!acc) begin
            #2 acc = rx_axis_tready;
            @(posedge clk);
            if (!acc) begin
                t++;
                if (t > 1000) begin chk("tready_tmo", 64'(rx_axis_tready), 64'd1); acc = 1; end
                else @(negedge clk);
            end
        end
    endtask

    task automatic send_frame(input bit with_last);
        for (int i = 0; i < fb.size(); i++) begin
            push_byte(fb[i], with_last && (i == fb.size() - 1));
            byte_no = i + 1;
        end
        @(negedge clk);
        rx_axis_tvalid = 0;
        rx_axis_tlast  = 0;
    endtask

    task automatic check_all(input string tag);
        int t;
        int nmin;
        t = 0;
        while (tdc_valid && t < 500) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
        #5;
        chk({tag, "_drained"}, 64'(tdc_valid), 64'd0);
        chk({tag, "_nwords"}, 64'(got_q.size()), 64'(exp_q.size()));
        nmin = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < nmin; i++) chk({tag, "_word"}, 64'(got_q[i]), 64'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
        chk({tag, "_frame"}, 64'(frame_count), 64'(m_frame));
        chk({tag, "_drop"}, 64'(drop_count), 64'(m_drop));
        chk({tag, "_runt"}, 64'(runt_count), 64'(m_runt));
        chk({tag, "_seqerr"}, 64'(seq_err_count), 64'(m_seqerr));
        chk({tag, "_lastseq"}, 64'(last_seq), 64'(m_last));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        rx_axis_tvalid = 0;
        rx_axis_tlast  = 0;
        #2;
        chk("rst_tready", 64'(rx_axis_tready), 64'd1);
        chk("rst_tvalid", 64'(tdc_valid), 64'd0);
        chk("rst_word", 64'(tdc_word), 64'd0);
        chk("rst_frame", 64'(frame_count), 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);
        chk("rst_runt", 64'(runt_count), 64'd0);
        chk("rst_seqerr", 64'(seq_err_count), 64'd0);
        chk("rst_lastseq", 64'(last_seq), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        m_frame = 0; m_drop = 0; m_runt = 0; m_seqerr = 0; m_last = 0; m_seen = 0;
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int kind, n;
        do_reset();

        for (int i = 0; i < 20; i++) wd[i] = 40'(i + 1);
        build(16'd1); send_frame(1); model_frame(1); check_all("basic");

        for (int i = 0; i < 20; i++) wd[i] = (i < 4) ? 40'(i + 1) : 40'hFFFFFFFFFF;
        build(16'd2); send_frame(1); model_frame(1); check_all("filler");

        rand_words(); build(16'd3); fb[10] = 8'h02;
        send_frame(1); model_frame(1); check_all("badsrc");
        rand_words(); build(16'd4); send_frame(1); model_frame(1); check_all("after_bad");

        rdy_full = 0;
        for (int i = 0; i < 20; i++) wd[i] = {8'hA5, 32'(i)};
        build(16'd5);
        while (fb.size() > 60) void'(fb.pop_back());
        saw_lo = 0;
        fork
            send_frame(1);
            begin
                for (int t = 0; t < 3000 && byte_no < 30; t++) @(negedge clk);
                stall = 1;
                repeat (50) @(negedge clk);
                stall = 0;
            end
        join
        model_frame(1); check_all("runt60");
        chk("stall_tready_low", 64'(saw_lo), 64'd1);

        rand_words(); build(16'd6); fb.push_back(8'h11); fb.push_back(8'h22);
        send_frame(1); model_frame(1); check_all("oversize");

        rand_words(); build(16'd7); enable = 0;
        send_frame(1); model_frame(0); enable = 1; check_all("disabled");

        for (int f = 0; f < 40; f++) begin
            kind = $urandom_range(0, 9);
            rand_words();
            build(($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'(m_last + 16'd1));
            if (kind == 5) begin
                n = $urandom_range(7, 14);
                fb[n-1] = fb[n-1] ^ 8'($urandom_range(1, 255));
            end else if (kind == 6) begin
                n = $urandom_range(1, 117);
                while (fb.size() > n) void'(fb.pop_back());
            end else if (kind == 7) begin
                n = $urandom_range(1, 3);
                for (int k = 0; k < n; k++) fb.push_back(8'($urandom));
            end
            if (kind == 8) enable = 0;
            send_frame(1);
            model_frame(kind != 8);
            enable = 1;
            check_all("rand");
        end

        do_reset();
        seqs[0] = 16'h0001; seqs[1] = 16'h0002; seqs[2] = 16'h0004;
        seqs[3] = 16'hFFFF; seqs[4] = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            rand_words(); build(seqs[i]); send_frame(1); model_frame(1); check_all("seq");
        end
`ifdef DATA_UNPACK_SEQ_CHECK_EN
        chk("seq_err_total", 64'(seq_err_count), 64'd2);
`else
        chk("seq_err_total", 64'(seq_err_count), 64'd0);
`endif

        rand_words(); build(16'd9);
        full = fb;
        while (fb.size() > 50) void'(fb.pop_back());
        send_frame(0);
        do_reset();
        fb = full[50:$];
        send_frame(1); model_frame(1); check_all("post_rst_tail");
        rand_words(); build(16'd10); send_frame(1); model_frame(1); check_all("post_rst_good");
        chk("post_rst_frame1", 64'(frame_count), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
